// File: rtl/calc_pkg.sv
// Shared codes for the calculator key path and ALU sequencer.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package calc_pkg;

    localparam int CALC_WIDTH = 16;

    // Decoded key kinds
    localparam logic [1:0] KEY_NUM   = 2'd0;
    localparam logic [1:0] KEY_OP    = 2'd1;
    localparam logic [1:0] KEY_EQUAL = 2'd2;
    localparam logic [1:0] KEY_CLEAR = 2'd3;

    // ALU operator codes
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;

    // Sequencer states
    localparam logic [2:0] ST_ENTER_A = 3'd0;
    localparam logic [2:0] ST_OP_WAIT = 3'd1;
    localparam logic [2:0] ST_ENTER_B = 3'd2;
    localparam logic [2:0] ST_ISSUE   = 3'd3;
    localparam logic [2:0] ST_EXEC    = 3'd4;
    localparam logic [2:0] ST_SHOW    = 3'd5;
    localparam logic [2:0] ST_ERROR   = 3'd6;

    // Only the four defined operators are acted on; codes 4-7 are ignored.
    function automatic logic op_is_valid(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    // Keypad codes 10-15 are accepted but carry no digit.
    function automatic logic digit_is_valid(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/calc_operand_entry.sv
// Decimal operand accumulator: clear, load first digit, append digit (value*10+d).
// Latency: value reflects a command on the cycle after the edge it is applied.
// Backpressure: none; appends beyond MAX_DIGITS are silently dropped.
module calc_operand_entry
    import calc_pkg::*;
#(
    parameter int WIDTH      = CALC_WIDTH,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             append,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] value
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [CW-1:0] count;

    // Clear has priority over load, load over append; the counter caps entry length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            count <= '0;
        end else if (clr) begin
            value <= '0;
            count <= '0;
        end else if (load) begin
            value <= WIDTH'(digit);
            count <= CW'(1);
        end else if (append && (count < CW'(MAX_DIGITS))) begin
            value <= value * WIDTH'(10) + WIDTH'(digit);
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/calc_alu_sequencer.sv
// Key-driven calculator controller: builds operands, chains ops left to right through an external ALU.
// Latency: key effects land on the accept edge; alu_start one cycle after the trigger key if ALU idle.
// Backpressure: key_ready low in ISSUE/EXEC except for CLEAR; alu_start held off while alu_busy.
module calc_alu_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH      = CALC_WIDTH,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [1:0]       key_kind,
    input  logic [3:0]       key_num,
    input  logic [2:0]       key_op,
    output logic             key_ready,
    output logic             alu_start,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic             alu_busy,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_div0,
    output logic [WIDTH-1:0] display,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             err
);

    logic [2:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opnd;
    logic [2:0]       pend_op;
    logic [2:0]       next_op;
    logic             trig_op;
    logic             drop;

    logic busy_state;
    logic accept;
    logic k_num, k_op, k_eq, k_clr;
    logic done_live;
    logic opnd_clr, opnd_load, opnd_append;

    assign busy_state = (state == ST_ISSUE) || (state == ST_EXEC);
    assign key_ready  = busy_state ? (key_kind == KEY_CLEAR) : 1'b1;
    assign accept     = key_valid && key_ready;

    assign k_num = accept && (key_kind == KEY_NUM) && digit_is_valid(key_num);
    assign k_op  = accept && (key_kind == KEY_OP) && op_is_valid(key_op);
    assign k_eq  = accept && (key_kind == KEY_EQUAL);
    assign k_clr = accept && (key_kind == KEY_CLEAR);

    // A CLEAR landing on the issue edge cancels the request rather than orphaning it.
    assign alu_start = (state == ST_ISSUE) && !alu_busy && !k_clr;

    // Completions are only consumed in EXEC and never while a stale one is still owed.
    assign done_live = alu_done && !drop && (state == ST_EXEC);

    assign result_valid = (state == ST_SHOW);
    assign err          = (state == ST_ERROR);

    // Operand accumulator commands derived from the accepted key and current state.
    always_comb begin
        opnd_clr    = 1'b0;
        opnd_load   = 1'b0;
        opnd_append = 1'b0;
        if (k_clr) begin
            opnd_clr = 1'b1;
        end else begin
            case (state)
                ST_ENTER_A: begin
                    if (k_num)     opnd_append = 1'b1;
                    else if (k_op) opnd_clr    = 1'b1;
                end
                ST_OP_WAIT: if (k_num) opnd_load   = 1'b1;
                ST_ENTER_B: if (k_num) opnd_append = 1'b1;
                ST_EXEC:    if (done_live && !alu_div0 && trig_op) opnd_clr = 1'b1;
                ST_SHOW:    if (k_num) opnd_load   = 1'b1;
                default:    ;
            endcase
        end
    end

    calc_operand_entry #(
        .WIDTH      (WIDTH),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_entry (
        .clk    (clk),
        .rst    (rst),
        .clr    (opnd_clr),
        .load   (opnd_load),
        .append (opnd_append),
        .digit  (key_num),
        .value  (opnd)
    );

    // Main sequencing FSM: operator chaining, ALU request latching, abort handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_ENTER_A;
            acc     <= '0;
            result  <= '0;
            pend_op <= OP_ADD;
            next_op <= OP_ADD;
            trig_op <= 1'b0;
            drop    <= 1'b0;
            alu_op  <= OP_ADD;
            alu_a   <= '0;
            alu_b   <= '0;
        end else begin
            // A stale completion from an aborted request retires the owed drop.
            if (alu_done && drop) drop <= 1'b0;

            if (k_clr) begin
                state   <= ST_ENTER_A;
                acc     <= '0;
                result  <= '0;
                pend_op <= OP_ADD;
                next_op <= OP_ADD;
                trig_op <= 1'b0;
                if (state == ST_EXEC) begin
                    // The ALU keeps running: owe one discard unless it finishes on this edge.
                    drop <= drop | !alu_done;
                end else begin
                    alu_op <= OP_ADD;
                    alu_a  <= '0;
                    alu_b  <= '0;
                end
            end else begin
                case (state)
                    ST_ENTER_A: begin
                        if (k_op) begin
                            acc     <= opnd;
                            pend_op <= key_op;
                            state   <= ST_OP_WAIT;
                        end else if (k_eq) begin
                            result <= opnd;
                            state  <= ST_SHOW;
                        end
                    end
                    ST_OP_WAIT: begin
                        if (k_op) begin
                            pend_op <= key_op;
                        end else if (k_num) begin
                            state <= ST_ENTER_B;
                        end else if (k_eq) begin
                            result <= acc;
                            state  <= ST_SHOW;
                        end
                    end
                    ST_ENTER_B: begin
                        if (k_op || k_eq) begin
                            alu_a   <= acc;
                            alu_b   <= opnd;
                            alu_op  <= pend_op;
                            trig_op <= k_op;
                            next_op <= key_op;
                            state   <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (alu_start) state <= ST_EXEC;
                    end
                    ST_EXEC: begin
                        if (done_live) begin
                            acc <= alu_result;
                            if (alu_div0) begin
                                state <= ST_ERROR;
                            end else if (trig_op) begin
                                pend_op <= next_op;
                                state   <= ST_OP_WAIT;
                            end else begin
                                result <= alu_result;
                                state  <= ST_SHOW;
                            end
                        end
                    end
                    ST_SHOW: begin
                        if (k_op) begin
                            acc     <= result;
                            pend_op <= key_op;
                            state   <= ST_OP_WAIT;
                        end else if (k_num) begin
                            state <= ST_ENTER_A;
                        end
                    end
                    ST_ERROR: ;
                    default:  state <= ST_ENTER_A;
                endcase
            end
        end
    end

    // Display source: entry during typing, running value while computing, zero on error.
    always_comb begin
        display = '0;
        case (state)
            ST_ENTER_A, ST_ENTER_B:          display = opnd;
            ST_OP_WAIT, ST_ISSUE, ST_EXEC:   display = acc;
            ST_SHOW:                         display = result;
            default:                         display = '0;
        endcase
    end

endmodule
